// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns the FIFO r_en/empty/data_out read port into a valid/ready stream
// through a 3-entry prefetch buffer whose head is entry 0.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_r_en,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            level
);
    logic [DATA_WIDTH-1:0] ent_q [3];
    logic [DATA_WIDTH-1:0] ent_d [3];
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic                  inflight_q;
    logic                  push;
    logic                  pop;
    logic [1:0]            idx;

    // words already held plus the one on its way must leave room, so a push never overflows
    assign fifo_r_en = rrst_n && !fifo_empty && !flush && (({1'b0, count_q} + {2'b0, inflight_q}) < 3'd3);
    assign pop       = m_valid && m_ready;
    assign push      = inflight_q && !flush;
    assign m_valid   = count_q != 2'd0;
    assign m_data    = ent_q[0];
    assign level     = count_q;

    // entries beyond count are kept at zero, so the head reads 0 whenever the buffer is empty
    always_comb begin
        ent_d[0] = pop ? ent_q[1] : ent_q[0];
        ent_d[1] = pop ? ent_q[2] : ent_q[1];
        ent_d[2] = pop ? '0 : ent_q[2];
        idx      = count_q - {1'b0, pop};
        for (int i = 0; i < 3; i++)
            if (push && idx == 2'(i)) ent_d[i] = fifo_data_out;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (flush) begin
            count_d = '0;
            for (int i = 0; i < 3; i++) ent_d[i] = '0;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < 3; i++) ent_q[i] <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            assert (!(push && !pop && count_q == 2'd3));
            for (int i = 0; i < 3; i++) ent_q[i] <= ent_d[i];
            count_q    <= count_d;
            inflight_q <= fifo_r_en;
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed checks of the stream reader against a behavioural FIFO
// and a sink log, with hand-derived cycle expectations.
module tb_fifo_stream_reader;
    logic       rclk;
    logic       rrst_n;
    logic       fifo_empty;
    logic [7:0] fifo_data_out;
    logic       fifo_r_en;
    logic       flush;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [1:0] level;

    logic [7:0] mem [64];
    logic [7:0] rxlog [64];
    int wp = 0;
    int rp = 0;
    int nrd = 0;
    int nrx = 0;
    int vecs = 0;
    int fails = 0;
    int n0;
    int base;

    fifo_stream_reader #(.DATA_WIDTH(8)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
        .fifo_r_en(fifo_r_en), .flush(flush), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .level(level)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    assign fifo_empty = (rp == wp);

    always @(posedge rclk) begin
        if (fifo_r_en && !fifo_empty) begin
            fifo_data_out <= mem[rp[5:0]];
            rp  <= rp + 1;
            nrd <= nrd + 1;
        end
        if (m_valid && m_ready) begin
            rxlog[nrx[5:0]] <= m_data;
            nrx <= nrx + 1;
        end
    end

    task automatic put(input logic [7:0] v);
        mem[wp[5:0]] = v;
        wp++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        fifo_data_out = 8'h00;
        rrst_n = 1'b1; flush = 1'b0; m_ready = 1'b0;
        #1 rrst_n = 1'b0;
        for (int i = 1; i <= 8; i++) put(8'(i));
        #2;
        chk("rst_ren", 32'(fifo_r_en), 1'b0);
        chk("rst_valid", 32'(m_valid), 1'b0);
        chk("rst_data", 32'(m_data), 8'h00);
        chk("rst_level", 32'(level), 2'd0);
        @(negedge rclk); @(negedge rclk);
        m_ready = 1'b1; rrst_n = 1'b1;
        #1 chk("first_ren", 32'(fifo_r_en), 1'b1);
        @(negedge rclk) chk("stream_lat1", 32'(m_valid), 1'b0);
        @(negedge rclk);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge rclk);
            chk("stream_valid", 32'(m_valid), 1'b1);
            chk("stream_data", 32'(m_data), 32'(i + 1));
            chk("stream_level", 32'(level), 2'd1);
        end
        @(negedge rclk);
        chk("stream_end_valid", 32'(m_valid), 1'b0);
        chk("stream_end_ren", 32'(fifo_r_en), 1'b0);

        m_ready = 1'b0; n0 = nrd;
        for (int i = 0; i < 6; i++) put(8'(8'h10 + i));
        repeat (6) @(negedge rclk);
        chk("bp_reads", 32'(nrd - n0), 32'd3);
        chk("bp_level", 32'(level), 2'd3);
        chk("bp_data", 32'(m_data), 8'h10);
        chk("bp_ren", 32'(fifo_r_en), 1'b0);
        repeat (2) @(negedge rclk);
        chk("bp_hold", 32'(m_data), 8'h10);
        m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge rclk);
            chk("bp_drain_valid", 32'(m_valid), 1'b1);
            chk("bp_drain_data", 32'(m_data), 32'(8'h10 + k));
        end
        @(negedge rclk) chk("bp_end_valid", 32'(m_valid), 1'b0);

        m_ready = 1'b0; n0 = nrd;
        for (int i = 0; i < 6; i++) put(8'(8'h30 + i));
        repeat (3) @(negedge rclk);
        chk("fl_level", 32'(level), 2'd2);
        chk("fl_reads", 32'(nrd - n0), 32'd3);
        flush = 1'b1;
        #1 chk("fl_ren", 32'(fifo_r_en), 1'b0);
        @(negedge rclk);
        flush = 1'b0;
        chk("fl_after_level", 32'(level), 2'd0);
        chk("fl_after_valid", 32'(m_valid), 1'b0);
        m_ready = 1'b1;
        repeat (2) @(negedge rclk);
        chk("fl_next_valid", 32'(m_valid), 1'b1);
        chk("fl_next_data", 32'(m_data), 8'h33);
        @(negedge rclk) chk("fl_next2", 32'(m_data), 8'h34);
        @(negedge rclk) chk("fl_next3", 32'(m_data), 8'h35);
        @(negedge rclk) chk("fl_end_valid", 32'(m_valid), 1'b0);

        n0 = nrd;
        put(8'hA5);
        repeat (2) @(negedge rclk);
        chk("em_valid", 32'(m_valid), 1'b1);
        chk("em_data", 32'(m_data), 8'hA5);
        @(negedge rclk);
        chk("em_after_valid", 32'(m_valid), 1'b0);
        chk("em_after_ren", 32'(fifo_r_en), 1'b0);
        chk("em_reads", 32'(nrd - n0), 32'd1);

        base = nrx;
        for (int i = 0; i < 16; i++) put(8'(8'h20 + i));
        for (int c = 0; c < 200 && nrx < base + 16; c++) begin
            @(negedge rclk);
            m_ready = !m_ready;
        end
        m_ready = 1'b1;
        repeat (4) @(negedge rclk);
        chk("alt_count", 32'(nrx - base), 32'd16);
        for (int i = 0; i < 16; i++) chk("alt_order", 32'(rxlog[6'(base + i)]), 32'(8'h20 + i));

        m_ready = 1'b0;
        put(8'h40); put(8'h41); put(8'h42); put(8'h43);
        repeat (2) @(negedge rclk);
        chk("mr_level_pre", 32'(level), 2'd1);
        rrst_n = 1'b0;
        #1;
        chk("mr_ren", 32'(fifo_r_en), 1'b0);
        chk("mr_level", 32'(level), 2'd0);
        chk("mr_valid", 32'(m_valid), 1'b0);
        chk("mr_data", 32'(m_data), 8'h00);
        @(negedge rclk);
        rrst_n = 1'b1;
        #1 chk("mr_resume_ren", 32'(fifo_r_en), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer of the asynchronous FIFO, clocked entirely in the read domain.
- Converts the FIFO's r_en/empty/data_out read interface into a valid/ready stream for downstream logic.
- Prefetches words into a 3-entry output buffer, so a continuously ready sink sees one word per cycle.
- There is no combinational path from m_ready to fifo_r_en.

Parameters:
DATA_WIDTH, 8, width of FIFO data word and stream payload

Ports:
rclk  input  1  read-domain clock
rrst_n  input  1  asynchronous active-low reset, read domain
fifo_empty  input  1  FIFO empty flag (read-domain, already synchronized)
fifo_data_out  input  DATA_WIDTH  FIFO read data; valid the cycle after an accepted fifo_r_en
fifo_r_en  output  1  FIFO read enable
flush  input  1  synchronous flush: discard buffered and in-flight words
m_valid  output  1  stream word available
m_data  output  DATA_WIDTH  stream payload (head of buffer)
m_ready  input  1  sink accepts word when m_valid && m_ready
level  output  2  number of words held in buffer (0..3)

Behaviour:
- Clock/reset: one clock, rclk. rrst_n is asynchronous, active-low.
- Reset state:
  - count=0, inflight=0, buffer entries=0.
  - m_valid=0, m_data=0, level=0.
  - fifo_r_en forced 0 while rrst_n low.
- FIFO read timing: a read is accepted when fifo_r_en=1 and fifo_empty=0. fifo_data_out carries that word exactly one rclk later.
- inflight register: set to 1 on the cycle after an accepted read, otherwise 0.
- Issue rule (combinational from registered state only):
  - fifo_r_en = !fifo_empty && !flush && (count + inflight) < 3.
  - Do not use m_ready in this term.
- Capture: when inflight=1 and flush=0, push fifo_data_out into the buffer tail.
- Pop: when m_valid && m_ready, remove the head. The next entry becomes the head on the following cycle.
- Simultaneous push and pop: count unchanged, FIFO order preserved. When count=1, the pushed word becomes the new head.
- Capacity: count + inflight never exceeds 3, so a push never overflows. Overflow is an assertion target.
- Outputs:
  - m_valid = (count != 0), registered.
  - m_data = head entry, registered. It holds stable while m_valid && !m_ready.
  - level = count.
- Throughput: with a non-empty FIFO and m_ready held 1, the steady state is one word per cycle after a 2-cycle startup (first m_valid 2 cycles after the first fifo_r_en).
- Flush (synchronous, takes priority over push and pop):
  - Next cycle: count=0, m_valid=0.
  - fifo_r_en=0 during the flush cycle.
  - A word arriving the cycle after flush (from a read issued before flush) is discarded: inflight is cleared by flush and that cycle's capture is suppressed.
  - Words remaining in the FIFO are not discarded; reads resume the cycle after flush deasserts.
- fifo_empty rising mid-stream: no new reads issue. The in-flight word is still captured.
- Reset mid-operation: all state clears immediately. The in-flight word is lost; fifo_r_en drops to 0 asynchronously.
- Stall: m_ready=0 with words arriving → buffer fills to 3, then fifo_r_en stays 0 until a pop occurs.
- Order: the stream order exactly equals the FIFO read order. No duplication, no loss except on flush or reset.

Test Plan:
- Reset: rrst_n=0 with fifo_empty=0 → fifo_r_en=0, m_valid=0, m_data=0, level=0. Release → fifo_r_en=1 on the first cycle.
- Streaming: FIFO preloaded with 0x01..0x08, m_ready=1 → m_valid first high 2 cycles after the first fifo_r_en, then 0x01..0x08 on 8 consecutive cycles, level never exceeds 1.
- Backpressure: m_ready=0, FIFO holds 0x10..0x15 → exactly 3 reads issued, level=3, m_data=0x10 stable. Raise m_ready → 0x10..0x15 delivered in order, no gaps after the first pop.
- Flush: level=2, inflight=1, flush pulse for 1 cycle → next cycle level=0, m_valid=0. The in-flight word is not delivered; the next delivered word is the following FIFO entry.
- Empty boundary: FIFO holds a single 0xA5 → one read, m_valid with 0xA5. After the pop, m_valid=0 and fifo_r_en=0 while fifo_empty=1.
- Alternating ready: m_ready toggles 1/0, FIFO holds 0x20..0x2F → all 16 words in order, each accepted exactly once, level ≤ 3 throughout.
